// File: rtl/counter_4bit.sv
// counter_4bit: free-running 4-bit counter with load, terminal count
// and a one-cycle wrap pulse. Optional macro: COUNTER_4BIT_SATURATE_EN.
//
// Parameters:
//   RESET_VALUE - value loaded into count by reset
//   MAX_VALUE   - terminal count (1..15); count wraps to 0 after it
// Ports:
//   clk       - clock, all state changes on the rising edge
//   reset_n   - synchronous reset, active HIGH despite the name
//   load      - synchronous parallel load request
//   load_data - value captured into count when load is 1
//   count     - registered counter value
//   tc        - combinational, 1 while count == MAX_VALUE
//   wrap      - registered, 1 for the cycle after count wraps to 0
//
// With COUNTER_4BIT_SATURATE_EN defined the counter holds at
// MAX_VALUE instead of wrapping and wrap never pulses.

module counter_4bit #(
  parameter logic [3:0] RESET_VALUE = 4'h0,
  parameter logic [3:0] MAX_VALUE   = 4'hF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_data,
  output logic [3:0] count,
  output logic       tc,
  output logic       wrap
);

  logic       at_top;
  logic [3:0] count_inc;
  logic [3:0] count_nxt;
  logic       wrap_nxt;

  // A loaded value above MAX_VALUE is treated like the terminal
  // count, so the next increment still lands in range.
  assign at_top    = (count >= MAX_VALUE);
  assign count_inc = count + 4'd1;

  always_comb begin
    count_nxt = count_inc;
    wrap_nxt  = 1'b0;
    if (at_top) begin
`ifdef COUNTER_4BIT_SATURATE_EN
      count_nxt = MAX_VALUE;
      wrap_nxt  = 1'b0;
`else
      count_nxt = 4'h0;
      wrap_nxt  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      count <= RESET_VALUE;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_data;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

  assign tc = (count == MAX_VALUE);

endmodule

// File: tb/tb_counter_4bit.sv
// tb_counter_4bit: vector table, corner sequences and random
// stimulus against a behavioural model for two parameterisations.

module tb_counter_4bit;

`ifdef COUNTER_4BIT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [3:0] load_data;
  logic [3:0] c0, c9;
  logic       tc0, tc9, w0, w9;

  always #5 clk = ~clk;

  counter_4bit u0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (load_data),
    .count     (c0),
    .tc        (tc0),
    .wrap      (w0)
  );

  counter_4bit #(
    .RESET_VALUE (4'h5),
    .MAX_VALUE   (4'h9)
  ) u9 (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (load_data),
    .count     (c9),
    .tc        (tc9),
    .wrap      (w9)
  );

  int checks   = 0;
  int failures = 0;
  int m0 = 0, m9 = 0;
  bit mw0 = 1'b0, mw9 = 1'b0;

  typedef struct {
    bit         r;
    bit         l;
    logic [3:0] d;
    logic [3:0] c;
    bit         tc;
    bit         w;
  } vec_t;

  vec_t vt[17];

  // Behavioural model: value as an integer, modulo (mx+1) counting.
  function automatic void model(inout int m, inout bit w,
                                input bit r, input bit l,
                                input int d, input int rv,
                                input int mx);
    if (r) begin
      m = rv; w = 1'b0;
    end else if (l) begin
      m = d; w = 1'b0;
    end else if (m >= mx) begin
      if (SAT) begin
        m = mx; w = 1'b0;
      end else begin
        m = 0; w = 1'b1;
      end
    end else begin
      m = (m + 1) % (mx + 1); w = 1'b0;
    end
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit l, input logic [3:0] d);
    int di;
    reset_n   = r;
    load      = l;
    load_data = d;
    di = l ? int'(d) : 0;
    @(posedge clk);
    #1;
    model(m0, mw0, r, l, di, 0, 15);
    model(m9, mw9, r, l, di, 5, 9);
    chk("u0_count", int'(c0), m0);
    chk("u0_tc", int'(tc0), int'(m0 == 15));
    chk("u0_wrap", int'(w0), int'(mw0));
    chk("u9_count", int'(c9), m9);
    chk("u9_tc", int'(tc9), int'(m9 == 9));
    chk("u9_wrap", int'(w9), int'(mw9));
  endtask

  initial begin
    reset_n   = 1'b1;
    load      = 1'b0;
    load_data = 4'h0;

    vt[0]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 4'h0, 4'h2, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 4'h0, 4'h3, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 4'h7, 4'h0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 4'h2, 4'h2, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 4'h0, 4'h3, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 4'h0, 4'h4, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 4'hA, 4'hA, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 4'hE, 4'hE, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b1, 4'hB, 4'hB, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 4'hE, 4'hE, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0};
    if (SAT) begin
      vt[13] = '{1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0};
      vt[14] = '{1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0};
    end else begin
      vt[13] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1};
      vt[14] = '{1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0};
    end
    vt[15] = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0};
    vt[16] = '{1'b0, 1'b1, 4'h3, 4'h3, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      step(vt[i].r, vt[i].l, vt[i].d);
      chk($sformatf("vec%0d_count", i), int'(c0), int'(vt[i].c));
      chk($sformatf("vec%0d_tc", i), int'(tc0), int'(vt[i].tc));
      chk($sformatf("vec%0d_wrap", i), int'(w0), int'(vt[i].w));
    end

    // Non-default parameters: reset value, and an out-of-range load.
    step(1'b1, 1'b0, 4'h0);
    chk("p9_reset_count", int'(c9), 5);
    chk("p9_reset_tc", int'(tc9), 0);
    step(1'b0, 1'b1, 4'hC);
    chk("p9_load_c", int'(c9), 12);
    step(1'b0, 1'b0, 4'h0);
    chk("p9_after_c_count", int'(c9), SAT ? 9 : 0);
    chk("p9_after_c_wrap", int'(w9), SAT ? 0 : 1);
    step(1'b0, 1'b0, 4'h0);
    chk("p9_next_count", int'(c9), SAT ? 9 : 1);
    chk("p9_next_wrap", int'(w9), 0);

    // Load while at terminal count must not pulse wrap.
    step(1'b0, 1'b1, 4'h9);
    step(1'b0, 1'b1, 4'h4);
    chk("p9_load_at_max_wrap", int'(w9), 0);
    chk("p9_load_at_max_count", int'(c9), 4);

    // Random traffic; load_data is X whenever load is low.
    for (int i = 0; i < 400; i++) begin
      bit         r;
      bit         l;
      logic [3:0] d;
      r = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 3) == 0);
      d = 4'($urandom_range(0, 15));
      if (!l && ($urandom_range(0, 1) == 0))
        d = 4'bxxxx;
      step(r, l, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_4bit.md
COUNTER_4BIT -- requirements
Module: counter_4bit

Interface
- REQ-001: Parameter RESET_VALUE, default 4'h0: value loaded into count by reset.
- REQ-002: Parameter MAX_VALUE, default 4'hF: terminal count; the count wraps from MAX_VALUE to 4'h0. Legal range is 1..15.
- REQ-003: clk, input, 1 bit: single clock; all state updates on the rising edge.
- REQ-004: reset_n, input, 1 bit: synchronous, active-high reset. The port name is retained for codebase compatibility; reset is asserted at 1 despite the _n suffix.
- REQ-005: load, input, 1 bit: synchronous parallel-load request.
- REQ-006: load_data, input, 4 bits: value written to count when load is sampled at 1.
- REQ-007: count, output, 4 bits: registered counter value.
- REQ-008: tc, output, 1 bit: combinational flag, 1 when count == MAX_VALUE.
- REQ-009: wrap, output, 1 bit: registered pulse, 1 for exactly one cycle after count wraps to 0.

Function
- REQ-010: Priority at each rising clk edge SHALL be: reset, then load, then increment.
- REQ-011: With reset_n=0 and load=1, count SHALL become load_data on the next edge. Latency is 1 cycle and wrap SHALL be 0.
- REQ-012: With reset_n=0 and load=0, count SHALL increment by 1 every cycle. There is no enable input; the counter free-runs.
- REQ-013: Increment from count == MAX_VALUE SHALL give 4'h0 and set wrap=1 for that cycle. Otherwise wrap SHALL be 0.
- REQ-014: A load_data value greater than MAX_VALUE SHALL load unchanged. The next increment from a value at or above MAX_VALUE SHALL give 4'h0 with wrap=1.
- REQ-015: Arithmetic SHALL be unsigned modulo (MAX_VALUE+1). The count output SHALL never carry X once reset has been applied.
- REQ-016: Load asserted while count == MAX_VALUE SHALL take load_data and SHALL NOT pulse wrap.
- REQ-017: Consecutive load cycles SHALL each capture that cycle's load_data, with no increment in between.
- REQ-018: X or Z on load_data SHALL only matter in cycles where load=1.

Reset
- REQ-019: reset_n=1 at a rising edge SHALL set count=RESET_VALUE and wrap=0, regardless of load.
- REQ-020: Reset asserted mid-count SHALL take effect at the next edge. There is no asynchronous path.
- REQ-021: After reset_n returns to 0, counting or loading SHALL resume on the following edge.
- REQ-022: tc SHALL reflect RESET_VALUE == MAX_VALUE while in reset.

Configuration
- REQ-023: Macro COUNTER_4BIT_SATURATE_EN defined: on reaching MAX_VALUE, count SHALL hold at MAX_VALUE rather than wrap, and wrap SHALL stay 0. Load and reset are unchanged; load can still exit saturation.
- REQ-024: Macro COUNTER_4BIT_SATURATE_EN undefined (default): wrap-around behaviour per REQ-013.

Verification
- REQ-025: Assert reset_n=1 for 1 edge with load=0, then release -> count=0. Over the next 3 edges count SHALL be 1, 2, 3.
- REQ-026: Release reset with load=1, load_data=4'b0010 -> count=2. Then load=0 -> count=3, 4 on successive edges.
- REQ-027: Hold load=1 for 3 edges with load_data 4'b1010, 4'b1110, 4'b1011 -> count SHALL be A, E, B in that order.
- REQ-028: Load 4'hE, then free-run -> count F with tc=1, then 0 with wrap=1 for one cycle, then 1. With COUNTER_4BIT_SATURATE_EN the sequence SHALL be F, F, F with wrap=0.
- REQ-029: Assert reset and load on the same edge with load_data=4'h7 -> count=RESET_VALUE.
- REQ-030: Set MAX_VALUE=9 and load 4'hC -> the next edge gives count=0 with wrap=1.
